flex_queue_rtl: RTL and testbench

- Parametrised N-entry val/rdy FIFO, successor to the single-entry normal queue.
- Generalises width, depth (any N >= 1, non-power-of-2 included) and flow-control mode: normal, pipe or bypass.
- Used as the standard buffering element between SPI datapath stages and between the SPI adapter and minion/master interfaces.

---
 rtl/flex_queue_rtl.sv | 90 +++++++++
 tb/tb_flex_queue_rtl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_queue_rtl.sv
// flex_queue_rtl: N-entry val/rdy FIFO with normal (0), pipe (1) and bypass (2) flow control.
// Define FLEX_QUEUE_AFULL_EN to add the almost_full output (threshold afull_thresh, clamped to 1..N).
module flex_queue_rtl #(
  parameter int nbits        = 8,
  parameter int num_entries  = 2,
  parameter int mode         = 0,
  parameter int afull_thresh = num_entries - 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [nbits-1:0]                 recv_msg,
  input  logic                             recv_val,
  output logic                             recv_rdy,
  output logic [nbits-1:0]                 send_msg,
  output logic                             send_val,
  input  logic                             send_rdy,
  output logic [$clog2(num_entries+1)-1:0] count
`ifdef FLEX_QUEUE_AFULL_EN
  ,
  output logic                             almost_full
`endif
);
  localparam int PW   = (num_entries > 1) ? $clog2(num_entries) : 1;
  localparam int CW   = $clog2(num_entries + 1);
  // A depth-1 queue still gets two slots so the 1-bit pointer indexes cleanly; slot 1 is never written.
  localparam int MD   = (num_entries > 1) ? num_entries : 2;
  localparam bit PIPE = (mode == 1);
  localparam bit BYP  = (mode == 2);

  localparam logic [PW-1:0] LAST = PW'(num_entries - 1);
  localparam logic [CW-1:0] FULL = CW'(num_entries);

  logic [MD-1:0][nbits-1:0] mem;
  logic [PW-1:0]            head, tail;
  logic                     empty, full;
  logic                     recv_xfer, send_xfer, thru, wr_en, rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL);

  always_comb begin
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = mem[head];
    if (!reset) begin
      recv_rdy = !full || (PIPE && send_rdy);
      send_val = !empty || (BYP && recv_val);
    end
    if (BYP && empty) send_msg = recv_msg;
  end

  assign recv_xfer = recv_val & recv_rdy;
  assign send_xfer = send_val & send_rdy;
  // Empty bypass with both sides moving: the message never touches storage.
  assign thru      = BYP & empty & recv_xfer & send_xfer;
  assign wr_en     = recv_xfer & ~thru;
  assign rd_en     = send_xfer & ~thru;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= ptr_inc(tail);
      if (rd_en) head <= ptr_inc(head);
      if (wr_en && !rd_en)      count <= count + CW'(1);
      else if (rd_en && !wr_en) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= recv_msg;
  end

`ifdef FLEX_QUEUE_AFULL_EN
  localparam int AT = (afull_thresh < 1) ? 1 :
                      (afull_thresh > num_entries) ? num_entries : afull_thresh;
  assign almost_full = !reset && (count >= CW'(AT));
`endif

  a_count_le_n: assert property (@(posedge clk) disable iff (reset) count <= FULL);
  a_no_over:    assert property (@(posedge clk) disable iff (reset) !(full && wr_en && !rd_en));
  a_no_under:   assert property (@(posedge clk) disable iff (reset) !(empty && rd_en));

endmodule

// File: tb/tb_flex_queue_rtl.sv
// Bench for flex_queue_rtl: four instances (normal N=4, normal N=3, pipe N=2, bypass N=2)
// checked every cycle against a list-based model plus directed literal expectations.
module tb_flex_queue_rtl;
  localparam int NI = 4;
  localparam int DEP[NI] = '{4, 3, 2, 2};
  localparam int MD[NI]  = '{0, 0, 1, 2};
  localparam int ATH[NI] = '{3, 2, 1, 1};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NI-1:0] rv, sr, rrdy, sval;
  logic [7:0]    rm[NI];
  logic [7:0]    sm[NI];
  logic [2:0]    c0;
  logic [1:0]    c1, c2, c3;
  logic [2:0]    cnt[NI];
  logic [NI-1:0] af;

  assign cnt[0] = c0;
  assign cnt[1] = {1'b0, c1};
  assign cnt[2] = {1'b0, c2};
  assign cnt[3] = {1'b0, c3};

  flex_queue_rtl #(.nbits(8), .num_entries(4), .mode(0), .afull_thresh(3)) u_n4 (
    .clk(clk), .reset(reset), .recv_msg(rm[0]), .recv_val(rv[0]), .recv_rdy(rrdy[0]),
    .send_msg(sm[0]), .send_val(sval[0]), .send_rdy(sr[0]), .count(c0)
`ifdef FLEX_QUEUE_AFULL_EN
    , .almost_full(af[0])
`endif
  );
  flex_queue_rtl #(.nbits(8), .num_entries(3), .mode(0)) u_n3 (
    .clk(clk), .reset(reset), .recv_msg(rm[1]), .recv_val(rv[1]), .recv_rdy(rrdy[1]),
    .send_msg(sm[1]), .send_val(sval[1]), .send_rdy(sr[1]), .count(c1)
`ifdef FLEX_QUEUE_AFULL_EN
    , .almost_full(af[1])
`endif
  );
  flex_queue_rtl #(.nbits(8), .num_entries(2), .mode(1)) u_p2 (
    .clk(clk), .reset(reset), .recv_msg(rm[2]), .recv_val(rv[2]), .recv_rdy(rrdy[2]),
    .send_msg(sm[2]), .send_val(sval[2]), .send_rdy(sr[2]), .count(c2)
`ifdef FLEX_QUEUE_AFULL_EN
    , .almost_full(af[2])
`endif
  );
  flex_queue_rtl #(.nbits(8), .num_entries(2), .mode(2)) u_b2 (
    .clk(clk), .reset(reset), .recv_msg(rm[3]), .recv_val(rv[3]), .recv_rdy(rrdy[3]),
    .send_msg(sm[3]), .send_val(sval[3]), .send_rdy(sr[3]), .count(c3)
`ifdef FLEX_QUEUE_AFULL_EN
    , .almost_full(af[3])
`endif
  );

`ifndef FLEX_QUEUE_AFULL_EN
  assign af = '0;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Model: queue contents as an ordered list; head is element 0.
  logic [7:0] mq[NI][4];
  int         mn[NI];

  function automatic logic m_rdy(input int i);
    if (reset) return 1'b0;
    if (MD[i] == 1) return (mn[i] < DEP[i]) || sr[i];
    return mn[i] < DEP[i];
  endfunction

  function automatic logic m_val(input int i);
    if (reset) return 1'b0;
    if (MD[i] == 2) return (mn[i] > 0) || rv[i];
    return mn[i] > 0;
  endfunction

  function automatic logic [7:0] m_msg(input int i);
    return (mn[i] == 0) ? rm[i] : mq[i][0];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic rx, sx, was_empty;
      if (reset) mn[i] = 0;
      else begin
        rx = rv[i] & m_rdy(i);
        sx = m_val(i) & sr[i];
        was_empty = (mn[i] == 0);
        if (sx && !was_empty) begin
          for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
          mn[i]--;
        end
        if (rx && !(sx && was_empty)) begin
          mq[i][mn[i]] = rm[i];
          mn[i]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("u%0d.recv_rdy", i), rrdy[i], m_rdy(i));
        chk($sformatf("u%0d.send_val", i), sval[i], m_val(i));
        if (m_val(i)) chk($sformatf("u%0d.send_msg", i), sm[i], m_msg(i));
        chk($sformatf("u%0d.count", i), cnt[i], mn[i]);
`ifdef FLEX_QUEUE_AFULL_EN
        chk($sformatf("u%0d.almost_full", i), af[i], !reset && (mn[i] >= ATH[i]));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int  nxt, got;
  logic rx1, sx1;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rv = '0; sr = '0;
    for (int i = 0; i < NI; i++) rm[i] = '0;
    cyc();
    chk_en = 1'b1;
    reset  = 1'b0;
    @(negedge clk);
    chk("reset.n4_rdy", rrdy[0], 1);
    chk("reset.n4_val", sval[0], 0);
    chk("reset.n4_cnt", cnt[0], 0);
    chk("reset.b2_val", sval[3], 0);
    cyc();

    // Normal N=4: fill with send_rdy low, then drain in order
    for (int k = 0; k < 4; k++) begin
      rv[0] = 1'b1; rm[0] = 8'(8'h11 * (k + 1));
      @(negedge clk);
      chk("n4.fill_cnt", cnt[0], k);
      chk("n4.fill_rdy", rrdy[0], 1);
`ifdef FLEX_QUEUE_AFULL_EN
      chk("n4.fill_af", af[0], (k >= 3) ? 1 : 0);
`endif
      cyc();
    end
    rm[0] = 8'hEE;
    @(negedge clk);
    chk("n4.full_cnt", cnt[0], 4);
    chk("n4.full_rdy", rrdy[0], 0);
    cyc();
    rv[0] = 1'b0; sr[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("n4.drain_val", sval[0], 1);
      chk("n4.drain_msg", sm[0], 8'h11 * (k + 1));
`ifdef FLEX_QUEUE_AFULL_EN
      chk("n4.drain_af", af[0], (k <= 1) ? 1 : 0);
`endif
      cyc();
    end
    @(negedge clk);
    chk("n4.empty_cnt", cnt[0], 0);
    chk("n4.empty_val", sval[0], 0);
    cyc();
    sr[0] = 1'b0;

    // Normal N=3: random handshakes, strict in-order delivery of 0..9
    nxt = 0; got = 0;
    for (int c = 0; c < 300 && got < 10; c++) begin
      rv[1] = (nxt < 10) && ($urandom_range(0, 1) == 1);
      rm[1] = 8'(nxt);
      sr[1] = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      rx1 = rv[1] & rrdy[1];
      sx1 = sval[1] & sr[1];
      if (sx1) chk("n3.order", sm[1], got);
      cyc();
      if (rx1) nxt++;
      if (sx1) got++;
    end
    chk("n3.all_delivered", got, 10);
    rv[1] = 1'b0; sr[1] = 1'b0;

    // Pipe N=2: full queue accepts while dequeuing
    rv[2] = 1'b1; rm[2] = 8'hA0; cyc();
    rm[2] = 8'hA1; cyc();
    rm[2] = 8'hA2; sr[2] = 1'b0;
    @(negedge clk);
    chk("p2.full_norecv", rrdy[2], 0);
    sr[2] = 1'b1;
    #1;
    chk("p2.full_rdy", rrdy[2], 1);
    chk("p2.full_msg", sm[2], 8'hA0);
    chk("p2.full_cnt", cnt[2], 2);
    cyc();
    rv[2] = 1'b0; sr[2] = 1'b0;
    @(negedge clk);
    chk("p2.after_cnt", cnt[2], 2);
    chk("p2.after_msg", sm[2], 8'hA1);
    sr[2] = 1'b1;
    cyc();
    @(negedge clk);
    chk("p2.last_msg", sm[2], 8'hA2);
    cyc();
    sr[2] = 1'b0;

    // Bypass N=2: pass-through when empty, store when send side stalls
    rv[3] = 1'b1; rm[3] = 8'h5C; sr[3] = 1'b1;
    @(negedge clk);
    chk("b2.thru_val", sval[3], 1);
    chk("b2.thru_msg", sm[3], 8'h5C);
    cyc();
    sr[3] = 1'b0;
    @(negedge clk);
    chk("b2.thru_cnt", cnt[3], 0);
    cyc();
    rv[3] = 1'b0; rm[3] = 8'h00;
    @(negedge clk);
    chk("b2.store_cnt", cnt[3], 1);
    chk("b2.store_msg", sm[3], 8'h5C);
    sr[3] = 1'b1;
    cyc();
    sr[3] = 1'b0;

    // Reset mid-stream: N=4 holding three entries
    rv[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin rm[0] = 8'(8'hC0 + k); cyc(); end
    reset = 1'b1; sr[0] = 1'b1;
    @(negedge clk);
    chk("rst.rdy", rrdy[0], 0);
    chk("rst.val", sval[0], 0);
    chk("rst.cnt_held", cnt[0], 3);
    cyc();
    reset = 1'b0; rv[0] = 1'b0; sr[0] = 1'b0;
    @(negedge clk);
    chk("rst.after_cnt", cnt[0], 0);
    chk("rst.after_val", sval[0], 0);
    chk("rst.after_rdy", rrdy[0], 1);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
